// File: rtl/dpd_pkg.sv
// Shared widths, constants and collector state encoding for the BCD-to-DPD packer.
package dpd_pkg;

    localparam int DIGIT_W  = 4;
    localparam int DECLET_W = 10;
    localparam int GROUP_W  = 3 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2
    } coll_state_e;

    // Non-BCD codes are replaced by zero before they enter a group.
    function automatic logic [DIGIT_W-1:0] sanitize_digit(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W-1:0] r;
        if (d > BCD_MAX) begin
            r = 4'd0;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/dpd_encode.sv
// Combinational IEEE 754 BCD-to-DPD encoder: three BCD digits (hundreds in the top nibble) to one declet.
module dpd_encode
    import dpd_pkg::*;
(
    input  logic [GROUP_W-1:0]  bcd_i,
    output logic [DECLET_W-1:0] declet_o
);

    logic a_s, b_s, c_s, d_s;
    logic e_s, f_s, g_s, h_s;
    logic i_s, j_s, k_s, m_s;

    assign {a_s, b_s, c_s, d_s} = bcd_i[11:8];
    assign {e_s, f_s, g_s, h_s} = bcd_i[7:4];
    assign {i_s, j_s, k_s, m_s} = bcd_i[3:0];

    // Select the packing pattern by which digits are large (8 or 9).
    always_comb begin
        declet_o = 10'd0;
        case ({a_s, e_s, i_s})
            3'b000:  declet_o = {b_s, c_s, d_s, f_s, g_s, h_s, 1'b0, j_s, k_s, m_s};
            3'b001:  declet_o = {b_s, c_s, d_s, f_s, g_s, h_s, 1'b1, 1'b0, 1'b0, m_s};
            3'b010:  declet_o = {b_s, c_s, d_s, j_s, k_s, h_s, 1'b1, 1'b0, 1'b1, m_s};
            3'b011:  declet_o = {b_s, c_s, d_s, 1'b1, 1'b0, h_s, 1'b1, 1'b1, 1'b1, m_s};
            3'b100:  declet_o = {j_s, k_s, d_s, f_s, g_s, h_s, 1'b1, 1'b1, 1'b0, m_s};
            3'b101:  declet_o = {f_s, g_s, d_s, 1'b0, 1'b1, h_s, 1'b1, 1'b1, 1'b1, m_s};
            3'b110:  declet_o = {j_s, k_s, d_s, 1'b0, 1'b0, h_s, 1'b1, 1'b1, 1'b1, m_s};
            3'b111:  declet_o = {1'b0, 1'b0, d_s, 1'b1, 1'b1, h_s, 1'b1, 1'b1, 1'b1, m_s};
            default: declet_o = 10'd0;
        endcase
    end

endmodule

// File: rtl/bcd_dpd_packer.sv
// Collects BCD digits into groups of three, encodes each group as a DPD declet
// and queues the declets in a small FIFO with valid/ready output handshake.
module bcd_dpd_packer
    import dpd_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [DIGIT_W-1:0]  in_digit,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    output logic [DECLET_W-1:0] out_declet,
    input  logic                out_ready,
    output logic                err,
    output logic [CNT_W-1:0]    count
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    coll_state_e          state_q, state_d;
    logic [DIGIT_W-1:0]   hund_q, hund_d;
    logic [DIGIT_W-1:0]   tens_q, tens_d;
    logic [DIGIT_W-1:0]   digit_s;
    logic                 accept_s;
    logic                 full_s;
    logic                 flush_ok_s;
    logic                 push_s;
    logic                 pop_s;
    logic [GROUP_W-1:0]   group_s;
    logic [DECLET_W-1:0]  declet_s;

    logic [DECLET_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_q;
    logic [PTR_W-1:0]     rd_q;
    logic [PTR_W:0]       occ_q, occ_d;
    logic                 out_valid_q;
    logic                 err_q;
    logic [CNT_W-1:0]     count_q;

    assign full_s     = (occ_q == DEPTH_C);
    assign in_ready   = ~full_s;
    assign accept_s   = in_valid & ~full_s;
    assign flush_ok_s = flush & ~full_s;
    assign digit_s    = sanitize_digit(in_digit);
    assign pop_s      = out_valid_q & out_ready;

    assign out_valid  = out_valid_q;
    assign out_declet = mem_q[rd_q];
    assign err        = err_q;
    assign count      = count_q;

    dpd_encode u_encode (
        .bcd_i    (group_s),
        .declet_o (declet_s)
    );

    // Collector state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= D0;
        end else begin
            state_q <= state_d;
        end
    end

    // Collector next state: a digit advances, a push (full group or effective flush) returns to D0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            D0: begin
                if (accept_s && !flush) begin
                    state_d = D1;
                end else begin
                    state_d = D0;
                end
            end
            D1: begin
                if (accept_s && !flush) begin
                    state_d = D2;
                end else if (accept_s || flush_ok_s) begin
                    state_d = D0;
                end else begin
                    state_d = D1;
                end
            end
            D2: begin
                if (accept_s || flush_ok_s) begin
                    state_d = D0;
                end else begin
                    state_d = D2;
                end
            end
            default: state_d = D0;
        endcase
    end

    // Collector outputs: digit holding, group assembly and push request.
    always_comb begin
        hund_d  = hund_q;
        tens_d  = tens_q;
        push_s  = 1'b0;
        group_s = 12'd0;
        case (state_q)
            D0: begin
                if (accept_s && flush) begin
                    push_s  = 1'b1;
                    group_s = {digit_s, 8'd0};
                end else if (accept_s) begin
                    hund_d  = digit_s;
                end else begin
                    push_s  = 1'b0;
                end
            end
            D1: begin
                if (accept_s && flush) begin
                    push_s  = 1'b1;
                    group_s = {hund_q, digit_s, 4'd0};
                    hund_d  = 4'd0;
                end else if (accept_s) begin
                    tens_d  = digit_s;
                end else if (flush_ok_s) begin
                    push_s  = 1'b1;
                    group_s = {hund_q, 8'd0};
                    hund_d  = 4'd0;
                end else begin
                    push_s  = 1'b0;
                end
            end
            D2: begin
                // A coincident flush is irrelevant here: the accept already closes the group.
                if (accept_s) begin
                    push_s  = 1'b1;
                    group_s = {hund_q, tens_q, digit_s};
                    hund_d  = 4'd0;
                    tens_d  = 4'd0;
                end else if (flush_ok_s) begin
                    push_s  = 1'b1;
                    group_s = {hund_q, tens_q, 4'd0};
                    hund_d  = 4'd0;
                    tens_d  = 4'd0;
                end else begin
                    push_s  = 1'b0;
                end
            end
            default: begin
                hund_d = 4'd0;
                tens_d = 4'd0;
            end
        endcase
    end

    // Held digit registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hund_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            hund_q <= hund_d;
            tens_q <= tens_d;
        end
    end

    // FIFO occupancy next value from simultaneous push/pop.
    always_comb begin
        occ_d = occ_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // FIFO storage, pointers and registered valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= {DECLET_W{1'b0}};
            end
            wr_q        <= {PTR_W{1'b0}};
            rd_q        <= {PTR_W{1'b0}};
            occ_q       <= {(PTR_W + 1){1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            if (push_s) begin
                mem_q[wr_q] <= declet_s;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            occ_q       <= occ_d;
            out_valid_q <= (occ_d != {(PTR_W + 1){1'b0}});
        end
    end

    // Sticky error flag and wrapping push counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q   <= 1'b0;
            count_q <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && (in_digit > BCD_MAX)) begin
                err_q <= 1'b1;
            end
            if (push_s) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_dpd_packer.sv
// Directed scoreboard bench for bcd_dpd_packer: expected declets are queued at issue time
// and a negedge monitor compares every handshaken output in order.
module tb_bcd_dpd_packer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_digit = 4'd0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic       out_valid;
    logic [9:0] out_declet;
    logic       out_ready = 1'b1;
    logic       err;
    logic [9:0] count;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_count = 10'd0;
    logic [9:0] exp_q [$];

    bcd_dpd_packer #(.FIFO_DEPTH(2), .CNT_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_digit   (in_digit),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_declet (out_declet),
        .out_ready  (out_ready),
        .err        (err),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_declet(input logic [9:0] d);
        exp_q.push_back(d);
        exp_count = exp_count + 10'd1;
    endtask

    // Present one digit (optionally with flush) and return just after the accepting edge.
    task automatic send(input logic [3:0] d, input logic fl);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_digit = d;
        flush    = fl;
        while (!in_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!in_ready) chk("send_timeout", 32'd1, {31'd0, in_ready});
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            tick();
            budget++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    // Monitor: compare each handshaken declet against the queue and check stability while stalled.
    initial begin
        logic       stalled;
        logic [9:0] held;
        logic [9:0] exp;
        stalled = 1'b0;
        held    = 10'd0;
        forever begin
            @(negedge clk);
            if (reset && out_valid) begin
                if (stalled) chk("stall_stable", {22'd0, out_declet}, {22'd0, held});
                if (out_ready) begin
                    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
                    if (exp_q.size() == 0 && exp == 10'h3FF) chk("unexpected_out", 32'hDEAD, {22'd0, out_declet});
                    else chk("declet", {22'd0, out_declet}, {22'd0, exp});
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_declet;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_declet", {22'd0, out_declet}, 32'd0);
        chk("rst_count", {22'd0, count}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 3,1,4 -> 0x194 visible right after the third accept edge
        expect_declet(10'h194);
        send(4'd3, 1'b0);
        send(4'd1, 1'b0);
        chk("no_early_valid", {31'd0, out_valid}, 32'd0);
        send(4'd4, 1'b0);
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_out_declet", {22'd0, out_declet}, 32'h194);
        chk("count_1", {22'd0, count}, {22'd0, exp_count});
        drain();

        // Back-to-back groups 159 / 999 / 000
        expect_declet(10'h0D9);
        expect_declet(10'h0FF);
        expect_declet(10'h000);
        send(4'd1, 1'b0); send(4'd5, 1'b0); send(4'd9, 1'b0);
        send(4'd9, 1'b0); send(4'd9, 1'b0); send(4'd9, 1'b0);
        send(4'd0, 1'b0); send(4'd0, 1'b0); send(4'd0, 1'b0);
        drain();
        chk("count_4", {22'd0, count}, {22'd0, exp_count});

        // Backpressure: two entries fill the buffer, digit 2 stalls
        out_ready = 1'b0;
        expect_declet(10'h194);
        expect_declet(10'h0D9);
        send(4'd3, 1'b0); send(4'd1, 1'b0); send(4'd4, 1'b0);
        send(4'd1, 1'b0); send(4'd5, 1'b0); send(4'd9, 1'b0);
        in_valid = 1'b1;
        in_digit = 4'd2;
        tick(); tick(); tick();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_head", {22'd0, out_declet}, 32'h194);
        chk("full_count", {22'd0, count}, {22'd0, exp_count});
        // Release; the stalled 2 is accepted together with flush in D0 -> 200 -> 0x100
        out_ready = 1'b1;
        begin
            int budget;
            budget = 0;
            while (!in_ready && budget < 20) begin
                tick();
                budget++;
            end
        end
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        expect_declet(10'h100);
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();
        chk("count_bp", {22'd0, count}, {22'd0, exp_count});

        // Flush in D1 -> 310, then flush in D0 has no effect
        expect_declet(10'h190);
        send(4'd3, 1'b0); send(4'd1, 1'b0);
        flush = 1'b1; tick(); flush = 1'b0;
        drain();
        flush = 1'b1; tick(); flush = 1'b0;
        tick(); tick();
        chk("d0_flush_count", {22'd0, count}, {22'd0, exp_count});
        chk("d0_flush_valid", {31'd0, out_valid}, 32'd0);

        // Flush coincident with accept in D1 (570) and in D2 (826, flush ignored)
        expect_declet(10'h2F0);
        send(4'd5, 1'b0); send(4'd7, 1'b1);
        expect_declet(10'h32C);
        send(4'd8, 1'b0); send(4'd2, 1'b0); send(4'd6, 1'b1);
        flush = 1'b1; tick(); flush = 1'b0;
        drain();
        chk("coinc_count", {22'd0, count}, {22'd0, exp_count});

        // Non-BCD digit is stored as 0 and sets sticky err
        chk("err_before", {31'd0, err}, 32'd0);
        expect_declet(10'h014);
        send(4'hC, 1'b0);
        chk("err_set", {31'd0, err}, 32'd1);
        send(4'd1, 1'b0); send(4'd4, 1'b0);
        drain();
        tick(); tick();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Counter wrap: 1024 single-digit flushed groups
        for (int n = 0; n < 1024; n++) begin
            expect_declet(10'h000);
            send(4'd0, 1'b1);
        end
        drain();
        chk("count_wrap", {22'd0, count}, {22'd0, exp_count});

        // Reset mid-group discards the partial 3,1
        send(4'd3, 1'b0); send(4'd1, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_count", {22'd0, count}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        exp_count = 10'd0;
        tick();
        reset = 1'b1;
        expect_declet(10'h0D9);
        send(4'd1, 1'b0); send(4'd5, 1'b0); send(4'd9, 1'b0);
        drain();
        tick(); tick();
        chk("post_rst_count", {22'd0, count}, 32'd1);
        chk("post_rst_err", {31'd0, err}, 32'd0);
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_dpd_packer.md
BCD_DPD_PACKER -- requirements
Module: bcd_dpd_packer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of output declet buffer entries (power of two, >=2).
REQ-002 Parameter: CNT_W, default 10, width of the declet counter.
REQ-003 Port: clk  input  1  sole clock, rising-edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  in_digit presented.
REQ-006 Port: in_digit  input  4  BCD digit, most significant digit of each group first.
REQ-007 Port: in_ready  output  1  digit accepted when in_valid & in_ready at clk edge.
REQ-008 Port: flush  input  1  close the partial group, zero-padded.
REQ-009 Port: out_valid  output  1  out_declet valid.
REQ-010 Port: out_declet  output  10  densely packed decimal declet, IEEE 754 DPD bit order, bit 0 = y.
REQ-011 Port: out_ready  input  1  declet consumed when out_valid & out_ready.
REQ-012 Port: err  output  1  sticky flag: a non-BCD digit was seen.
REQ-013 Port: count  output  CNT_W  number of declets pushed, modulo 2^CNT_W.

Function
REQ-014 Collector FSM states: D0, D1, D2, meaning 0, 1 or 2 digits held. Each accept advances D0->D1->D2. In D2, an accept pushes the group and returns to D0.
REQ-015 in_ready = buffer not full. It is independent of the FSM state and of in_valid.
REQ-016 A digit >9 is accepted, stored as 0, and sets err on the same edge. err clears only on reset.
REQ-017 Group digit order: 1st accepted = hundreds, 2nd = tens, 3rd = units. The encoded value is the 3-digit number.
REQ-018 Encoding: standard IEEE 754 BCD-to-DPD. Examples: 314->0x194, 159->0x0D9, 999->0x0FF, 000->0x000.
REQ-019 Flush in D1/D2 with the buffer not full: push the held digits with missing low-order digits set to 0, then go to D0. Example: "31"+flush gives 310 -> 0x190.
REQ-020 Flush in D0, or while the buffer is full: no effect. Flush is not latched; the source holds it.
REQ-021 Flush coincident with a digit accept in D0/D1: the digit is included first, then the padded group is pushed on the same edge. In D2 the coincident accept completes the group normally and flush is ignored.
REQ-022 Latency: a push makes out_valid=1 on the next cycle when the buffer was empty. There is no combinational path from inputs to out_valid or out_declet.
REQ-023 Output buffer is a FIFO, strict order. out_declet and out_valid stay stable while out_valid & !out_ready.
REQ-024 Push and pop on the same edge: both occur and occupancy is unchanged. A full buffer never accepts a push, per REQ-015.
REQ-025 count increments on each push, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-026 reset low asynchronously forces: FSM=D0, held digits=0, buffer empty, out_valid=0, out_declet=0, err=0, count=0.
REQ-027 After reset deasserts, in_ready=1 in the first cycle. A partial group interrupted by reset is discarded and never emitted.

Structure
REQ-028 Shared package dpd_pkg holds DIGIT_W=4, DECLET_W=10, the collector state enum {D0,D1,D2} and the BCD_MAX=9 constant.
REQ-029 One combinational sub-module, dpd_encode: 12-bit BCD in, 10-bit declet out. It is the inverse of the team's existing DPD decoder.
REQ-030 The top level contains the FSM, digit registers, FIFO and counter, and no other sub-modules.

Verification
REQ-031 Digits 3,1,4 with out_ready=1 -> out_valid=1 one cycle after the 3rd accept, out_declet=0x194, count=1.
REQ-032 Groups 1,5,9 / 9,9,9 / 0,0,0 back-to-back -> declets 0x0D9, 0x0FF, 0x000 in order, count=3.
REQ-033 out_ready=0, feed 3,1,4,1,5,9,2 -> two entries buffered, in_ready=0, digit 2 stalled. Release -> 0x194 then 0x0D9, then 2 is accepted.
REQ-034 Digits 3,1 then a one-cycle flush -> 0x190. Flush again in D0 -> no push, count unchanged.
REQ-035 Digits 0xC,1,4 -> err=1 from the accept edge of 0xC, declet 0x014, err stays 1 afterwards.
REQ-036 Digits 3,1, reset low for one cycle, then 1,5,9 -> only 0x0D9 emitted, count=1, err=0.
